// File: rtl/div_seq.sv
// div_seq: iterative 32-bit radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU.
// One operation in flight. The result is held until it is taken. flush and reset abort any
// in-flight operation.
// Optional feature: define DIV_EARLY_OUT_EN to skip the iteration phase when |src1| < |src2|.
//
// Handshakes (valid/ready):
//   A request transfers on a clock edge where req_valid & req_ready are both high. req_op,
//   req_src1 and req_src2 are sampled on that edge. A response transfers on a clock edge where
//   resp_valid & resp_ready are both high. resp_valid and resp_result stay stable until then.
//   resp_valid never depends combinationally on any input.
module div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q;          // {div_w, mod_w, div_wu, mod_wu}
  logic [31:0] src1_q, src2_q;
  logic [31:0] dvs_q;         // divisor magnitude
  logic [31:0] quot_q;
  logic [63:0] rem_q;         // {partial remainder, remaining dividend bits}
  logic [4:0]  count_q;
  logic        neg_quot_q, neg_rem_q, special_q;

  logic        op_signed, op_div;
  logic [31:0] abs1, abs2;
  logic        div_zero, overflow, early_out, prep_skip;
  logic [32:0] trial_hi;
  logic [33:0] trial_diff;
  logic        trial_ok;
  logic [31:0] quot_fix, rem_fix;
  logic        unused_bits;

  assign op_signed = op_q[3] | op_q[2];
  assign op_div    = op_q[3] | op_q[1];
  assign abs1      = (op_signed && src1_q[31]) ? -src1_q : src1_q;
  assign abs2      = (op_signed && src2_q[31]) ? -src2_q : src2_q;
  assign div_zero  = (src2_q == 32'd0);
  assign overflow  = op_signed && (src1_q == 32'h8000_0000) && (src2_q == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
  assign early_out = !div_zero && (abs1 < abs2);
`else
  assign early_out = 1'b0;
`endif
  assign prep_skip = div_zero | overflow | early_out;

  // The shifted partial remainder can reach 33 bits, so the trial subtract is done at 34 bits.
  // When it succeeds the difference is below the divisor and fits back into 32 bits.
  assign trial_hi    = rem_q[63:31];
  assign trial_diff  = {1'b0, trial_hi} - {2'b00, dvs_q};
  assign trial_ok    = !trial_diff[33];
  assign unused_bits = trial_diff[32];

  // Special-case results are already final and bypass the sign fixup.
  assign quot_fix = (neg_quot_q && !special_q) ? -quot_q : quot_q;
  assign rem_fix  = (neg_rem_q && !special_q) ? -rem_q[63:32] : rem_q[63:32];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and handshake-ready decode; flush overrides every transition.
  always_comb begin
    state_d   = state_q;
    req_ready = (state_q == S_IDLE) && !flush && !reset;
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
    case (state_q)
      S_IDLE: if (req_valid && req_ready) state_d = S_PREP;
      S_PREP: state_d = prep_skip ? S_FIX : S_ITER;
      S_ITER: if (count_q == 5'd31) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Operand latch, iteration datapath and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= 4'd0;
      src1_q      <= 32'd0;
      src2_q      <= 32'd0;
      dvs_q       <= 32'd0;
      quot_q      <= 32'd0;
      rem_q       <= 64'd0;
      count_q     <= 5'd0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      special_q   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_result <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_q   <= req_op;
            src1_q <= req_src1;
            src2_q <= req_src2;
          end
        end
        S_PREP: begin
          count_q    <= 5'd0;
          dvs_q      <= abs2;
          neg_quot_q <= op_signed && (src1_q[31] ^ src2_q[31]);
          neg_rem_q  <= op_signed && src1_q[31];
          special_q  <= div_zero | overflow;
          if (div_zero) begin
            quot_q <= 32'hFFFF_FFFF;
            rem_q  <= {src1_q, 32'd0};
          end else if (overflow) begin
            quot_q <= 32'h8000_0000;
            rem_q  <= 64'd0;
          end else if (early_out) begin
            quot_q <= 32'd0;
            rem_q  <= {abs1, 32'd0};
          end else begin
            quot_q <= 32'd0;
            rem_q  <= {32'd0, abs1};
          end
        end
        S_ITER: begin
          count_q <= count_q + 5'd1;
          quot_q  <= {quot_q[30:0], trial_ok};
          rem_q   <= trial_ok ? {trial_diff[31:0], rem_q[30:0], 1'b0}
                              : {trial_hi[31:0], rem_q[30:0], 1'b0};
        end
        S_FIX: begin
          resp_result <= op_div ? quot_fix : rem_fix;
          resp_valid  <= 1'b1;
        end
        S_DONE: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
      if (flush) resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and randomized bench for div_seq against a behavioural divide model.
module tb_div_seq;

  localparam logic [3:0] OP_DIV_W  = 4'b1000;
  localparam logic [3:0] OP_MOD_W  = 4'b0100;
  localparam logic [3:0] OP_DIV_WU = 4'b0010;
  localparam logic [3:0] OP_MOD_WU = 4'b0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        busy;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  div_seq dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Behavioural model: architectural DIV/MOD result.
  function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic        sgn;
    logic        want_q;
    logic [31:0] q, r;
    sgn    = op[3] | op[2];
    want_q = op[3] | op[1];
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return want_q ? q : r;
  endfunction

  // Behavioural model: accept-to-resp_valid latency in cycles.
  function automatic int model_lat(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    logic        sgn;
    logic [31:0] aa, bb;
    sgn = op[3] | op[2];
    aa  = (sgn && a[31]) ? -a : a;
    bb  = (sgn && b[31]) ? -b : b;
    if (b == 32'd0) return 2;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (aa < bb) return 2;
`else
    if (aa < bb && aa == 32'hFFFF_FFFF) return 0;
`endif
    return 34;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
    end
  endtask

  // Scoreboard: every cycle a response is offered it must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got 0x%08h expected no response", resp_result);
      end else begin
        check("resp_result", resp_result, exp_q[0]);
        if (resp_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  // Driver: present a request and hold it until the accept edge.
  task automatic accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n         = 0;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    req_valid = 1'b1;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Driver: wait for the response, apply backpressure, then take it.
  task automatic await_resp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int bp);
    int n;
    n = 0;
    exp_q.push_back(model_res(op, a, b));
    while (resp_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(model_lat(op, a, b)));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_result", resp_result, model_res(op, a, b));
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("post_busy", 32'(busy), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
    check("post_resp_valid", 32'(resp_valid), 32'd0);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int bp);
    accept(op, a, b);
    await_resp(op, a, b, bp);
  endtask

  // Stimulus.
  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 4'd0;
    req_src1   = 32'd0;
    req_src2   = 32'd0;
    flush      = 1'b0;
    resp_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_result", resp_result, 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);

    // Hand-computed values pinning the model.
    check("model_div_100_7", model_res(OP_DIV_W, 32'd100, 32'd7), 32'd14);
    check("model_mod_m7_2", model_res(OP_MOD_W, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("model_div_m7_2", model_res(OP_DIV_W, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model_divu_max_1", model_res(OP_DIV_WU, 32'hFFFF_FFFF, 32'd1), 32'hFFFF_FFFF);
    check("model_modu_10_0", model_res(OP_MOD_WU, 32'd10, 32'd0), 32'd10);
    check("model_div_5_0", model_res(OP_DIV_W, 32'd5, 32'd0), 32'hFFFF_FFFF);
    check("model_div_ovf", model_res(OP_DIV_W, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("model_mod_ovf", model_res(OP_MOD_W, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
    check("model_div_3_m7", model_res(OP_DIV_W, 32'd3, 32'hFFFF_FFF9), 32'd0);
    check("model_mod_3_m7", model_res(OP_MOD_W, 32'd3, 32'hFFFF_FFF9), 32'd3);
    check("model_lat_normal", 32'(model_lat(OP_DIV_W, 32'd100, 32'd7)), 32'd34);
    check("model_lat_zero", 32'(model_lat(OP_MOD_WU, 32'd10, 32'd0)), 32'd2);

    // Directed operations.
    run_op(OP_DIV_W,  32'd100,        32'd7,         0);
    run_op(OP_MOD_W,  32'hFFFF_FFF9,  32'd2,         1);
    run_op(OP_DIV_W,  32'hFFFF_FFF9,  32'd2,         0);
    run_op(OP_DIV_WU, 32'hFFFF_FFFF,  32'd1,         0);
    run_op(OP_MOD_WU, 32'd10,         32'd0,         0);
    run_op(OP_DIV_W,  32'd5,          32'd0,         0);
    run_op(OP_DIV_W,  32'h8000_0000,  32'hFFFF_FFFF, 0);
    run_op(OP_MOD_W,  32'h8000_0000,  32'hFFFF_FFFF, 0);
    run_op(OP_DIV_W,  32'd3,          32'hFFFF_FFF9, 0);
    run_op(OP_MOD_W,  32'd3,          32'hFFFF_FFF9, 0);
    run_op(OP_DIV_W,  32'd1000,       32'd10,        5);

    // Flush during ITER, with a request presented in the flush cycle.
    accept(OP_DIV_W, 32'd100, 32'd7);
    repeat (12) @(posedge clk);
    #1;
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_DIV_W;
    req_src1  = 32'd9;
    req_src2  = 32'd3;
    @(negedge clk);
    check("flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_resp_valid", 32'(resp_valid), 32'd0);
    accept(OP_DIV_W, 32'd9, 32'd3);
    await_resp(OP_DIV_W, 32'd9, 32'd3, 0);

    // Reset in the middle of an operation.
    accept(OP_DIV_WU, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midreset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_resp_valid", 32'(resp_valid), 32'd0);
    check("midreset_resp_result", resp_result, 32'd0);
    run_op(OP_MOD_WU, 32'd1000, 32'd3, 0);

    // Randomized operations with boundary-biased operands.
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int          sel;
      op  = 4'(4'b0001 << $urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 100));
        4: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        5: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(op, a, b, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-bit integer divider with its own sequencing FSM, serving DIV.W/MOD.W/DIV.WU/MOD.WU in the EXE stage. It accepts one operation at a time through a valid/ready handshake and runs a radix-2 restoring division over 32 iteration cycles. It presents the result under a hold-until-taken response handshake and aborts cleanly on pipeline flush (exception/ertn). EXE derives `EXE_ready_go` for divide ops from `resp_valid`.

## Interface
- No parameters; width fixed at 32.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: EXE holds a valid divide op.
- `req_ready` out 1: divider can accept; high only in IDLE with `flush`=0 and `reset`=0.
- `req_op` in 4: one-hot {div_w, mod_w, div_wu, mod_wu}; sampled on accept.
- `req_src1` in 32: dividend; sampled on accept.
- `req_src2` in 32: divisor; sampled on accept.
- `flush` in 1: cancel any in-flight op. Driven by exe_ex | mem_ex | mem_ertn | wb_ex | ertn_flush.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: EXE consumes the result (EXE_valid & MEM_allowin).
- `resp_result` out 32: quotient or remainder per latched op.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: on `req_valid & req_ready`, latch op, src1 and src2 → PREP.
- PREP:
  - Signed ops: latch |src1| and |src2|, sign_q = s1[31]^s2[31], sign_r = s1[31].
  - Unsigned ops: use operands as-is, signs 0.
  - Clear the 64-bit partial remainder and the quotient. Set count=0.
  - Next state is ITER, with these special cases:
    - Divisor==0 → FIX directly with quotient=0xFFFFFFFF, remainder=src1 (original, unsigned view). No sign fixup.
    - Signed 0x80000000 / 0xFFFFFFFF → FIX directly with quotient=0x80000000, remainder=0.
- ITER, one quotient bit per cycle, MSB first:
  - Shift the remainder left by 1 with the next dividend bit.
  - Trial subtract the divisor (33-bit). If non-negative, keep the difference and set q bit = 1.
  - count increments; after the iteration with count==31 → FIX.
- FIX:
  - Apply sign_q to the quotient and sign_r to the remainder (two's-complement negate). Skipped for the special cases.
  - Select the output: quotient for div_*, remainder for mod_*. Register it into `resp_result`.
  - → DONE.
- DONE: `resp_valid`=1, `resp_result` stable. On `resp_ready` → IDLE. Held indefinitely while `resp_ready`=0.
- `flush` has priority over every transition:
  - From any state, the next state is IDLE.
  - `resp_valid` is 0 from the next cycle.
  - `resp_result` is not required to change.
  - `req_ready` is 0 in the flush cycle, so a request presented in the flush cycle is dropped.
- After `flush` or `resp_ready`, IDLE → `req_ready` is high the following cycle. There is no back-to-back accept from DONE.

## Timing
- Reset values: state=IDLE, `resp_valid`=0, `resp_result`=0, `busy`=0, count=0. `req_ready`=0 while `reset` is high.
- Accept at edge E0 (the handshake cycle is the cycle before E0).
- Normal op: PREP in [E0,E1), ITER in [E1,E33), FIX in [E33,E34). `resp_valid` is high from E34, i.e. 34 cycles after accept.
- Special cases (div-by-zero, overflow): `resp_valid` is high from E2.
- `resp_valid` and `resp_result` are registered with no combinational path from inputs. `req_ready` is combinational from state, `flush` and `reset`.
- `reset` mid-operation behaves identically to `flush`, plus all registers return to their reset values.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - In PREP, if the unsigned |src1| < |src2| (divisor nonzero), skip ITER with quotient=0 and remainder=|src1|. Then FIX applies signs as normal.
  - Latency in this case is 2 cycles.
- Undefined: every non-special op takes the full 34 cycles.

## Test plan
- div_w 100/7 accepted at E0 → `resp_valid` rises at E34 with `resp_result`=14. With resp_ready=1 at E34, IDLE and `req_ready`=1 at E35.
- mod_w 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFF (-1). div_w on the same operands → 0xFFFFFFFD (-3).
- div_wu 0xFFFFFFFF/1 → 0xFFFFFFFF. mod_wu 10/0 → 10 at E2. div_w 5/0 → 0xFFFFFFFF at E2.
- div_w 0x80000000/0xFFFFFFFF → 0x80000000. mod_w on the same operands → 0 at E2.
- Flush at E12 during ITER:
  - `busy`=0 at E13 and `resp_valid` never rises for that op.
  - A new div_w 9/3 accepted at E13 → 3 at E47.
  - A request presented in the flush cycle itself is not accepted.
- Backpressure: hold resp_ready=0 for 5 cycles after `resp_valid` rises → result and `resp_valid` stable, `req_ready`=0. Then release → IDLE next cycle.
- With `DIV_EARLY_OUT_EN`: div_w 3/0xFFFFFFF9 (3/-7) → 0 at E2. mod_w on the same operands → 3 at E2.
